// File: rtl/keypad_matrix_scanner.sv
// rtl/keypad_matrix_scanner.sv - 4x4 keypad column scanner with debounce and one event per press.
// Optional auto-repeat while held is enabled by defining KEYPAD_REPEAT_EN.
module keypad_matrix_scanner #(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 4,
  parameter int REPEAT_CNT   = 50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] key_row,
  output logic [3:0] key_col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_pressed
);

  localparam int DIVW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int DW   = $clog2(DEBOUNCE_CNT + 1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

  state_t          state_q, state_d;
  logic [3:0]      row_meta_q, row_meta_d, row_s_q, row_s_d;
  logic [DIVW-1:0] div_cnt_q, div_cnt_d;
  logic [1:0]      col_idx_q, col_idx_d;
  logic [1:0]      lat_row_q, lat_row_d, lat_col_q, lat_col_d;
  logic [DW-1:0]   match_cnt_q, match_cnt_d, rel_cnt_q, rel_cnt_d;
  logic [3:0]      key_code_q, key_code_d;
  logic            key_valid_q, key_valid_d;
  logic            key_pressed_q, key_pressed_d;
  logic            sample, accept;
  logic [1:0]      first_low, acc_row, acc_col;

`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_CNT + 1);
  logic [RW-1:0] rpt_cnt_q, rpt_cnt_d;
`endif

  always_comb begin
    row_meta_d    = key_row;
    row_s_d       = row_meta_q;
    state_d       = state_q;
    div_cnt_d     = div_cnt_q + 1'b1;
    col_idx_d     = col_idx_q;
    lat_row_d     = lat_row_q;
    lat_col_d     = lat_col_q;
    match_cnt_d   = match_cnt_q;
    rel_cnt_d     = rel_cnt_q;
    key_code_d    = key_code_q;
    key_valid_d   = 1'b0;
    key_pressed_d = key_pressed_q;
    accept        = 1'b0;
    acc_row       = lat_row_q;
    acc_col       = lat_col_q;
`ifdef KEYPAD_REPEAT_EN
    rpt_cnt_d     = rpt_cnt_q;
`endif

    sample = (div_cnt_q == DIVW'(SCAN_DIV - 1));
    if (sample) div_cnt_d = '0;

    // Lowest-index low row wins when several keys share the driven column.
    first_low = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!row_s_q[i]) first_low = 2'(i);
    end

    case (state_q)
      SCAN: begin
        if (sample) begin
          if (row_s_q == 4'b1111) begin
            col_idx_d = col_idx_q + 2'd1;
          end else begin
            lat_row_d = first_low;
            lat_col_d = col_idx_q;
            acc_row   = first_low;
            acc_col   = col_idx_q;
            if (DEBOUNCE_CNT == 1) begin
              accept = 1'b1;
            end else begin
              match_cnt_d = DW'(1);
              state_d     = DEBOUNCE;
            end
          end
        end
      end
      DEBOUNCE: begin
        if (sample) begin
          if (!row_s_q[lat_row_q]) begin
            match_cnt_d = match_cnt_q + 1'b1;
            if (match_cnt_q + 1'b1 == DW'(DEBOUNCE_CNT)) accept = 1'b1;
          end else begin
            state_d   = SCAN;
            col_idx_d = col_idx_q + 2'd1;
          end
        end
      end
      HELD: begin
        if (sample) begin
          if (row_s_q[lat_row_q]) begin
            rel_cnt_d = rel_cnt_q + 1'b1;
`ifdef KEYPAD_REPEAT_EN
            rpt_cnt_d = '0;
`endif
            if (rel_cnt_q + 1'b1 == DW'(DEBOUNCE_CNT)) begin
              rel_cnt_d     = '0;
              key_pressed_d = 1'b0;
              state_d       = SCAN;
              col_idx_d     = col_idx_q + 2'd1;
            end
          end else begin
            rel_cnt_d = '0;
`ifdef KEYPAD_REPEAT_EN
            if (rpt_cnt_q + 1'b1 == RW'(REPEAT_CNT)) begin
              rpt_cnt_d   = '0;
              key_valid_d = 1'b1;
            end else begin
              rpt_cnt_d = rpt_cnt_q + 1'b1;
            end
`endif
          end
        end
      end
      default: state_d = SCAN;
    endcase

    if (accept) begin
      key_valid_d   = 1'b1;
      key_code_d    = {acc_row, acc_col};
      key_pressed_d = 1'b1;
      match_cnt_d   = '0;
      rel_cnt_d     = '0;
      state_d       = HELD;
`ifdef KEYPAD_REPEAT_EN
      rpt_cnt_d     = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= SCAN;
      row_meta_q    <= 4'b1111;
      row_s_q       <= 4'b1111;
      div_cnt_q     <= '0;
      col_idx_q     <= 2'd0;
      lat_row_q     <= 2'd0;
      lat_col_q     <= 2'd0;
      match_cnt_q   <= '0;
      rel_cnt_q     <= '0;
      key_code_q    <= 4'd0;
      key_valid_q   <= 1'b0;
      key_pressed_q <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rpt_cnt_q     <= '0;
`endif
    end else begin
      state_q       <= state_d;
      row_meta_q    <= row_meta_d;
      row_s_q       <= row_s_d;
      div_cnt_q     <= div_cnt_d;
      col_idx_q     <= col_idx_d;
      lat_row_q     <= lat_row_d;
      lat_col_q     <= lat_col_d;
      match_cnt_q   <= match_cnt_d;
      rel_cnt_q     <= rel_cnt_d;
      key_code_q    <= key_code_d;
      key_valid_q   <= key_valid_d;
      key_pressed_q <= key_pressed_d;
`ifdef KEYPAD_REPEAT_EN
      rpt_cnt_q     <= rpt_cnt_d;
`endif
    end
  end

  assign key_col     = ~(4'b0001 << col_idx_q);
  assign key_code    = key_code_q;
  assign key_valid   = key_valid_q;
  assign key_pressed = key_pressed_q;

endmodule

// File: doc/keypad_matrix_scanner.md
Name: keypad_matrix_scanner

Overview:
- Input-side counterpart to the team's scanned LED matrix display driver for the OOXX board.
- Scans a 4x4 key matrix: drives one column at a time, reads the row lines, debounces and emits one coded key event per press.
- Sits between the board keypad pins and the game controller, which uses key_code to select a cell.

Parameters:
SCAN_DIV, 1000, clk cycles each column is driven; the sample is taken on the last cycle of the slot; legal range is 2 or more.
DEBOUNCE_CNT, 4, consecutive matching samples needed to accept a press or a release; legal range is 1 or more.
REPEAT_CNT, 50, samples between auto-repeat events; used only when KEYPAD_REPEAT_EN is defined.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
key_row  input  4  row sense lines, active-low (0 = pressed key on the driven column), asynchronous to clk
key_col  output  4  column drive, one-cold active-low
key_code  output  4  row*4 + col of the last accepted key
key_valid  output  1  one-cycle pulse per accepted key event
key_pressed  output  1  high while the accepted key is held

Behaviour:
- Single clock, clk. Reset is synchronous and active-high, named reset.
- key_row passes through a 2-flop synchronizer to give row_s. All decisions use row_s.
- div_cnt counts 0..SCAN_DIV-1. A sample point is the cycle where div_cnt == SCAN_DIV-1.
- col_idx is 2 bits. key_col = ~(4'b0001 << col_idx).
- Reset values: key_col=4'b1110, key_code=0, key_valid=0, key_pressed=0, state=SCAN. All counters are 0.
- Reset asserted mid-operation: reset values apply on the next edge. No key_valid is emitted for a partially debounced key.
- States:
  - SCAN: at a sample point with row_s==4'b1111, col_idx increments (wraps 3 to 0). At a sample point with any bit low, lat_row = lowest-index low bit, lat_col = col_idx, match_cnt=1, go to DEBOUNCE. If DEBOUNCE_CNT==1, accept immediately (see below).
  - DEBOUNCE: col_idx is frozen. At each sample point:
    - row_s[lat_row]==0: match_cnt++.
    - Otherwise: go to SCAN and increment col_idx.
    - When match_cnt reaches DEBOUNCE_CNT: the next cycle gives key_valid=1 for exactly one cycle, key_code={lat_row,lat_col}, key_pressed=1, then go to HELD.
  - HELD: col_idx is frozen. At each sample point:
    - row_s[lat_row]==1: rel_cnt++.
    - Otherwise: rel_cnt=0.
    - When rel_cnt reaches DEBOUNCE_CNT: key_pressed=0, go to SCAN, increment col_idx.
    - No key_valid in HELD.
- Latency: key_valid rises 1 cycle after the DEBOUNCE_CNT-th matching sample point.
- Simultaneous keys: only the lowest row index in the first column found wins. All other keys are ignored until release completes. A second key pressed while HELD never produces an event.
- key_code holds its value after release until the next accepted key.
- div_cnt free-runs in every state, so sample spacing is always SCAN_DIV.

Optional Feature:
- Macro: KEYPAD_REPEAT_EN.
- Defined: in HELD, a repeat counter counts sample points at which the key is still pressed. When it reaches REPEAT_CNT it re-emits a one-cycle key_valid with the same key_code, then clears. The counter clears on entry to HELD and whenever rel_cnt is nonzero.
- Undefined: exactly one key_valid per press. The REPEAT_CNT logic is absent.

Test Plan:
(Bench uses SCAN_DIV=4, DEBOUNCE_CNT=3, REPEAT_CNT=5.)
1. Reset, then key_row=4'b1111 held -> key_col steps 1110, 1101, 1011, 0111, 1110 every 4 cycles; key_valid stays 0.
2. key_row[2]=0 whenever key_col==1101, held for 20 samples -> exactly one key_valid, with key_code=4'd9; key_pressed=1; key_col stays 1101 throughout.
3. Bounce: key 9 pressed for 2 samples then released -> no key_valid; key_col advances to 1011 at the next sample point.
4. Release after test 2 -> key_pressed falls after the 3rd released sample; no second key_valid; scan resumes at key_col=1011; key_code stays 9.
5. Rows 1 and 3 both low on column 0 -> single event with key_code=4'd4; pressing column-2 keys while HELD yields no event.
6. reset pulsed after 2 matching samples of key 9 -> key_col=1110 and key_pressed=0 next cycle, with no key_valid. With KEYPAD_REPEAT_EN, holding key 9 gives additional key_valid pulses every 5 samples, each with code 9.
